// File: rtl/i2c_slave_serial_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_slave_serial_ctrl
// Byte-level I2C slave controller. Works from an already debounced and
// delayed bus (sclDly / sdaDebOut) plus a START/STOP detector, and turns
// bus transactions into register-file accesses:
//   write: START, {ADDR,W}, register address, data bytes..., STOP
//   read : START, {ADDR,R}, data bytes sent until the master NACKs, STOP
// The register address auto-increments (wrapping at 8'hFF) after every data
// byte and is kept across repeated STARTs.
//
// Ports
//   clk               in   system clock, all logic on its rising edge
//   rst               in   synchronous active-low reset
//   rstSerialI2c      in   bit-level restart from the debouncer (repeated START)
//   sclDly            in   delayed, debounced SCL
//   sdaDebOut         in   debounced SDA
//   startStopDetState in   detector status: 0 = none, 1 = START, 2 = STOP
//   sdaDebIn          out  SDA drive: 0 pulls low, 1 releases
//   clearStartStopDet out  one-cycle pulse clearing the detector status
//   regAddr           out  current register-file address
//   dataToRegIf       out  write data
//   writeEn           out  one-cycle register write strobe
//   readEn            out  one-cycle register read strobe
//   dataFromRegIf     in   read data, valid one clk after readEn
// -----------------------------------------------------------------------------
module i2c_slave_serial_ctrl #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h3C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rstSerialI2c,
    input  logic       sclDly,
    input  logic       sdaDebOut,
    input  logic [1:0] startStopDetState,
    output logic       sdaDebIn,
    output logic       clearStartStopDet,
    output logic [7:0] regAddr,
    output logic [7:0] dataToRegIf,
    output logic       writeEn,
    output logic       readEn,
    input  logic [7:0] dataFromRegIf
);

    localparam logic [1:0] DET_START = 2'd1;
    localparam logic [1:0] DET_STOP  = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_RX_ADDR     = 4'd1,
        ST_ADDR_ACK    = 4'd2,
        ST_RX_REGADDR  = 4'd3,
        ST_REGADDR_ACK = 4'd4,
        ST_RX_DATA     = 4'd5,
        ST_DATA_ACK    = 4'd6,
        ST_TX_DATA     = 4'd7,
        ST_TX_ACKCHK   = 4'd8,
        ST_WAIT_STOP   = 4'd9
    } state_t;

    state_t      state_q;
    logic        scl_q;
    logic [7:0]  shift_q;     // receive shift register, reused as transmit shifter
    logic [3:0]  bitcnt_q;    // counts SCL rises within the current 9-clock frame
    logic        rw_q;        // 1 = read transaction
    logic        nack_q;      // master acknowledge bit sampled in TX_ACKCHK
    logic [1:0]  txstep_q;    // 1: readEn cycle, 2: load data, 3: drive bit 7
    logic        sda_q;
    logic        clear_q;
    logic        wen_q;
    logic        ren_q;
    logic [7:0]  regaddr_q;
    logic [7:0]  wdata_q;

    logic        scl_rise;
    logic        scl_fall;
    logic [7:0]  rx_byte_d;

    assign scl_rise  = sclDly & ~scl_q;
    assign scl_fall  = ~sclDly & scl_q;
    // Byte value including the bit being sampled on this rise.
    assign rx_byte_d = {shift_q[6:0], sdaDebOut};

    assign sdaDebIn          = sda_q;
    assign clearStartStopDet = clear_q;
    assign regAddr           = regaddr_q;
    assign dataToRegIf       = wdata_q;
    assign writeEn           = wen_q;
    assign readEn            = ren_q;

    // Protocol FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            scl_q     <= 1'b1;
            shift_q   <= 8'h00;
            bitcnt_q  <= 4'd0;
            rw_q      <= 1'b0;
            nack_q    <= 1'b1;
            txstep_q  <= 2'd0;
            sda_q     <= 1'b1;
            clear_q   <= 1'b0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            regaddr_q <= 8'h00;
            wdata_q   <= 8'h00;
        end else begin
            scl_q   <= sclDly;
            clear_q <= 1'b0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            // Post-write increment happens the cycle after the strobe, so the
            // register file sees the pre-increment address with writeEn.
            if (wen_q) begin
                regaddr_q <= regaddr_q + 8'd1;
            end

            if (startStopDetState == DET_STOP) begin
                // STOP wins over everything; a partial byte is simply dropped.
                state_q  <= ST_IDLE;
                sda_q    <= 1'b1;
                clear_q  <= 1'b1;
                bitcnt_q <= 4'd0;
                shift_q  <= 8'h00;
                txstep_q <= 2'd0;
            end else if (rstSerialI2c && (state_q != ST_IDLE)) begin
                // Repeated START: restart address phase, keep regAddr.
                state_q  <= ST_RX_ADDR;
                sda_q    <= 1'b1;
                clear_q  <= 1'b1;
                bitcnt_q <= 4'd0;
                shift_q  <= 8'h00;
                txstep_q <= 2'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (startStopDetState == DET_START) begin
                            state_q  <= ST_RX_ADDR;
                            clear_q  <= 1'b1;
                            bitcnt_q <= 4'd0;
                            shift_q  <= 8'h00;
                        end
                    end
                    ST_RX_ADDR, ST_RX_REGADDR, ST_RX_DATA: begin
                        if (scl_rise) begin
                            shift_q  <= rx_byte_d;
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd7) begin
                                case (state_q)
                                    ST_RX_ADDR: begin
                                        if (rx_byte_d[7:1] == DEVICE_ADDRESS) begin
                                            state_q <= ST_ADDR_ACK;
                                            rw_q    <= rx_byte_d[0];
                                        end else begin
                                            state_q <= ST_WAIT_STOP;
                                            sda_q   <= 1'b1;
                                        end
                                    end
                                    ST_RX_REGADDR: begin
                                        regaddr_q <= rx_byte_d;
                                        state_q   <= ST_REGADDR_ACK;
                                    end
                                    default: begin
                                        wdata_q <= rx_byte_d;
                                        wen_q   <= 1'b1;
                                        state_q <= ST_DATA_ACK;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_REGADDR_ACK, ST_DATA_ACK: begin
                        // bitcnt 8: falling edge after bit 8 starts the ACK;
                        // bitcnt 9: falling edge after the 9th clock ends it.
                        if (scl_rise) begin
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end else if (scl_fall && (bitcnt_q == 4'd8)) begin
                            sda_q <= 1'b0;
                        end else if (scl_fall && (bitcnt_q == 4'd9)) begin
                            sda_q    <= 1'b1;
                            bitcnt_q <= 4'd0;
                            shift_q  <= 8'h00;
                            if (state_q != ST_ADDR_ACK) begin
                                state_q <= ST_RX_DATA;
                            end else if (rw_q) begin
                                state_q  <= ST_TX_DATA;
                                ren_q    <= 1'b1;
                                txstep_q <= 2'd1;
                            end else begin
                                state_q <= ST_RX_REGADDR;
                            end
                        end
                    end
                    ST_TX_DATA: begin
                        case (txstep_q)
                            2'd1: txstep_q <= 2'd2;
                            2'd2: begin
                                shift_q  <= dataFromRegIf;
                                txstep_q <= 2'd3;
                            end
                            2'd3: begin
                                sda_q     <= shift_q[7];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                regaddr_q <= regaddr_q + 8'd1;
                                txstep_q  <= 2'd0;
                            end
                            default: begin
                                if (scl_rise) begin
                                    bitcnt_q <= bitcnt_q + 4'd1;
                                    if (bitcnt_q == 4'd7) begin
                                        state_q <= ST_TX_ACKCHK;
                                    end
                                end else if (scl_fall && (bitcnt_q != 4'd0)) begin
                                    sda_q   <= shift_q[7];
                                    shift_q <= {shift_q[6:0], 1'b0};
                                end
                            end
                        endcase
                    end
                    ST_TX_ACKCHK: begin
                        if (scl_rise) begin
                            bitcnt_q <= bitcnt_q + 4'd1;
                            nack_q   <= sdaDebOut;
                        end else if (scl_fall && (bitcnt_q == 4'd8)) begin
                            sda_q <= 1'b1;
                        end else if (scl_fall && (bitcnt_q == 4'd9)) begin
                            bitcnt_q <= 4'd0;
                            if (nack_q) begin
                                state_q <= ST_WAIT_STOP;
                            end else begin
                                state_q  <= ST_TX_DATA;
                                ren_q    <= 1'b1;
                                txstep_q <= 2'd1;
                            end
                        end
                    end
                    ST_WAIT_STOP: begin
                        sda_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        sda_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_serial_ctrl
// Bus-level master plus register-file model around i2c_slave_serial_ctrl.
// Expected results come from a transaction-level model: an expected memory
// image and an expected register pointer updated by the I2C rules.
// -----------------------------------------------------------------------------
module tb_i2c_slave_serial_ctrl;

    localparam int H = 6;   // clk cycles per SCL phase

    logic       clk;
    logic       rst;
    logic       rstSerialI2c;
    logic       sclDly;
    logic       sdaDebOut;
    logic [1:0] startStopDetState;
    logic       sdaDebIn;
    logic       clearStartStopDet;
    logic [7:0] regAddr;
    logic [7:0] dataToRegIf;
    logic       writeEn;
    logic       readEn;
    logic [7:0] dataFromRegIf;

    i2c_slave_serial_ctrl #(.DEVICE_ADDRESS(7'h3C)) dut (
        .clk               (clk),
        .rst               (rst),
        .rstSerialI2c      (rstSerialI2c),
        .sclDly            (sclDly),
        .sdaDebOut         (sdaDebOut),
        .startStopDetState (startStopDetState),
        .sdaDebIn          (sdaDebIn),
        .clearStartStopDet (clearStartStopDet),
        .regAddr           (regAddr),
        .dataToRegIf       (dataToRegIf),
        .writeEn           (writeEn),
        .readEn            (readEn),
        .dataFromRegIf     (dataFromRegIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         clr_cnt = 0;
    logic       m_sda;
    logic [7:0] mem     [0:255];   // register file served to the DUT
    logic [7:0] exp_mem [0:255];   // expected register contents
    logic [7:0] exp_ptr;           // expected register pointer
    logic [7:0] wbuf    [0:3];
    logic [7:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    logic [7:0] rd_addr_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance to the falling edge, resolve the wired-AND bus and
    // serve the register-file side.
    task automatic tick();
        @(negedge clk);
        sdaDebOut = m_sda & sdaDebIn;
        if (writeEn) begin
            mem[regAddr] = dataToRegIf;
            wr_addr_q.push_back(regAddr);
            wr_data_q.push_back(dataToRegIf);
        end
        if (readEn) begin
            dataFromRegIf = mem[regAddr];
            rd_addr_q.push_back(regAddr);
        end
        if (clearStartStopDet) clr_cnt++;
    endtask

    task automatic set_sda(input logic b);
        m_sda     = b;
        sdaDebOut = m_sda & sdaDebIn;
    endtask

    // Low phase then high phase; SCL is left low on return.
    task automatic scl_pulse(output logic smp, output logic stab, output logic wen_first);
        repeat (H) tick();
        sclDly = 1'b1;
        tick();
        wen_first = writeEn;
        repeat (H/2 - 1) tick();
        smp = sdaDebOut;
        repeat (H/2) tick();
        stab = (sdaDebOut === smp);
        sclDly = 1'b0;
    endtask

    task automatic start_cond();
        int c0;
        if (sclDly == 1'b0) begin
            set_sda(1'b1);
            repeat (H) tick();
            sclDly = 1'b1;
            repeat (H) tick();
        end
        set_sda(1'b0);
        startStopDetState = 2'd1;
        rstSerialI2c = 1'b1;
        c0 = clr_cnt;
        for (int k = 0; k < 10; k++) begin
            tick();
            rstSerialI2c = 1'b0;
            if (clr_cnt != c0) break;
        end
        check("start_clear", 32'(clr_cnt - c0), 32'd1);
        startStopDetState = 2'd0;
        repeat (H) tick();
        sclDly = 1'b0;
    endtask

    task automatic stop_cond(output int pulses);
        int c0;
        set_sda(1'b0);
        repeat (H) tick();
        sclDly = 1'b1;
        repeat (H) tick();
        set_sda(1'b1);
        startStopDetState = 2'd2;
        c0 = clr_cnt;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (clr_cnt != c0) break;
        end
        startStopDetState = 2'd0;
        repeat (4) tick();
        pulses = clr_cnt - c0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic do_rst,
                             output logic ack, output logic wen8);
        logic s, st, w;
        wen8 = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            set_sda(b[i]);
            scl_pulse(s, st, w);
            if (i == 0) wen8 = w;
        end
        set_sda(1'b1);
        repeat (H/2) tick();
        if (do_rst) begin
            check("rst_ack_low", 32'(sdaDebIn), 32'd0);
            rst = 1'b0;
            tick();
            rst = 1'b1;
            check("rst_sda", 32'(sdaDebIn), 32'd1);
            check("rst_regaddr", 32'(regAddr), 32'h00);
        end
        repeat (H - H/2) tick();
        sclDly = 1'b1;
        repeat (H/2) tick();
        ack = sdaDebOut;
        repeat (H/2) tick();
        sclDly = 1'b0;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b, output logic stab_all);
        logic s, st, w;
        b = 8'h00;
        stab_all = 1'b1;
        set_sda(1'b1);
        for (int i = 7; i >= 0; i--) begin
            scl_pulse(s, st, w);
            b[i] = s;
            stab_all = stab_all & st;
        end
        set_sda(mack);
        scl_pulse(s, st, w);
        set_sda(1'b1);
    endtask

    task automatic do_write(input logic [7:0] ra, input int n);
        logic ack, w;
        int   p;
        wr_addr_q.delete();
        wr_data_q.delete();
        start_cond();
        send_byte(8'h78, 1'b0, ack, w);
        check("w_addr_ack", 32'(ack), 32'd0);
        send_byte(ra, 1'b0, ack, w);
        check("w_reg_ack", 32'(ack), 32'd0);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], 1'b0, ack, w);
            check("w_data_ack", 32'(ack), 32'd0);
            check("w_wen_timing", 32'(w), 32'd1);
        end
        stop_cond(p);
        check("w_stop_clear", 32'(p), 32'd1);
        check("w_count", 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check("w_addr", 32'(wr_addr_q[i]), 32'(8'(ra + 8'(i))));
            check("w_data", 32'(wr_data_q[i]), 32'(wbuf[i]));
        end
        for (int i = 0; i < n; i++) exp_mem[8'(ra + 8'(i))] = wbuf[i];
        exp_ptr = 8'(ra + 8'(n));
        check("w_regaddr", 32'(regAddr), 32'(exp_ptr));
    endtask

    task automatic do_read(input int n);
        logic       ack, w, s, st;
        logic [7:0] b;
        int         p;
        rd_addr_q.delete();
        start_cond();
        send_byte(8'h79, 1'b0, ack, w);
        check("r_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < n; i++) begin
            recv_byte(1'(i == n - 1), b, st);
            check("r_data", 32'(b), 32'(exp_mem[8'(exp_ptr + 8'(i))]));
            check("r_stable", 32'(st), 32'd1);
        end
        // After the NACK the slave must stay off the bus.
        scl_pulse(s, st, w);
        check("r_waitstop_sda", 32'(s), 32'd1);
        check("r_count", 32'(rd_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < rd_addr_q.size(); i++) begin
            check("r_addr", 32'(rd_addr_q[i]), 32'(8'(exp_ptr + 8'(i))));
        end
        stop_cond(p);
        check("r_stop_clear", 32'(p), 32'd1);
        exp_ptr = 8'(exp_ptr + 8'(n));
        check("r_regaddr", 32'(regAddr), 32'(exp_ptr));
    endtask

    initial begin
        logic       ack, w, s, st;
        logic [7:0] b;
        int         p;

        rst = 1'b0;
        rstSerialI2c = 1'b0;
        sclDly = 1'b1;
        m_sda = 1'b1;
        sdaDebOut = 1'b1;
        startStopDetState = 2'd0;
        dataFromRegIf = 8'h00;
        exp_ptr = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            exp_mem[i] = mem[i];
        end

        // Reset state
        repeat (3) tick();
        check("reset_sda", 32'(sdaDebIn), 32'd1);
        check("reset_clear", 32'(clearStartStopDet), 32'd0);
        check("reset_wen", 32'(writeEn), 32'd0);
        check("reset_ren", 32'(readEn), 32'd0);
        check("reset_regaddr", 32'(regAddr), 32'h00);
        check("reset_wdata", 32'(dataToRegIf), 32'h00);
        rst = 1'b1;
        repeat (4) tick();

        // Directed write: 0x10 <- A5, 5A
        wbuf[0] = 8'hA5;
        wbuf[1] = 8'h5A;
        do_write(8'h10, 2);

        // Write wrapping across 8'hFF
        for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
        do_write(8'hFE, 3);
        do_write(8'hFF, 0);
        do_read(2);

        // Directed read from 0x20, ACK then NACK
        do_write(8'h20, 0);
        do_read(2);

        // Address mismatch: no ACK, no strobes until STOP
        wr_addr_q.delete();
        rd_addr_q.delete();
        start_cond();
        send_byte(8'h7A, 1'b0, ack, w);
        check("mm_no_ack", 32'(ack), 32'd1);
        send_byte(8'h55, 1'b0, ack, w);
        check("mm_waitstop_no_ack", 32'(ack), 32'd1);
        check("mm_no_wen", 32'(wr_addr_q.size()), 32'd0);
        check("mm_no_ren", 32'(rd_addr_q.size()), 32'd0);
        stop_cond(p);
        check("mm_stop_clear", 32'(p), 32'd1);
        check("mm_regaddr", 32'(regAddr), 32'(exp_ptr));

        // Repeated START: set pointer to 0x30, then read
        wr_addr_q.delete();
        rd_addr_q.delete();
        start_cond();
        send_byte(8'h78, 1'b0, ack, w);
        check("rs_addr_ack", 32'(ack), 32'd0);
        send_byte(8'h30, 1'b0, ack, w);
        check("rs_reg_ack", 32'(ack), 32'd0);
        start_cond();
        send_byte(8'h79, 1'b0, ack, w);
        check("rs_read_ack", 32'(ack), 32'd0);
        recv_byte(1'b1, b, st);
        check("rs_data", 32'(b), 32'(exp_mem[8'h30]));
        check("rs_ren_count", 32'(rd_addr_q.size()), 32'd1);
        if (rd_addr_q.size() > 0) check("rs_ren_addr", 32'(rd_addr_q[0]), 32'h30);
        check("rs_no_wen", 32'(wr_addr_q.size()), 32'd0);
        stop_cond(p);
        check("rs_stop_clear", 32'(p), 32'd1);
        exp_ptr = 8'h31;
        check("rs_regaddr", 32'(regAddr), 32'(exp_ptr));

        // Abort after 4 data bits
        wr_addr_q.delete();
        start_cond();
        send_byte(8'h78, 1'b0, ack, w);
        send_byte(8'h40, 1'b0, ack, w);
        check("ab_reg_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) begin
            set_sda(1'($urandom));
            scl_pulse(s, st, w);
        end
        stop_cond(p);
        check("ab_clear_once", 32'(p), 32'd1);
        check("ab_no_wen", 32'(wr_addr_q.size()), 32'd0);
        exp_ptr = 8'h40;
        check("ab_regaddr", 32'(regAddr), 32'(exp_ptr));

        // Reset while the address ACK is driven low
        start_cond();
        send_byte(8'h78, 1'b1, ack, w);
        check("rst_ack_released", 32'(ack), 32'd1);
        stop_cond(p);
        exp_ptr = 8'h00;
        check("rst_regaddr_after", 32'(regAddr), 32'(exp_ptr));

        // Randomized write/read-back transactions
        for (int k = 0; k < 4; k++) begin
            logic [7:0] ra;
            int         n;
            ra = 8'($urandom);
            n  = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            do_write(ra, n);
            do_write(ra, 0);
            do_read(n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
